// File: rtl/aqed_rd_checker_if.sv
// Read-port bundle between the environment, the A-QED read monitor and the
// memory core: request address in, presented address out, response data back.
interface aqed_rd_checker_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              ren_in;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_out;
    logic              valid_out;
    logic [DATA_W-1:0] data_out_in;

    modport master (
        output ren_in,
        output addr_in,
        output valid_out,
        output data_out_in,
        input  addr_out
    );

    modport slave (
        input  ren_in,
        input  addr_in,
        input  valid_out,
        input  data_out_in,
        output addr_out
    );
endinterface

// File: rtl/aqed_rd_checker.sv
// A-QED read-side monitor: tags an original and a duplicate read, replays the
// original address on the duplicate, compares both responses, bounds latency.
module aqed_rd_checker #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 32,
    parameter int RB_BOUND = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              exec_dup,
    aqed_rd_checker_if.slave  rd,
    output logic              qed_done,
    output logic              qed_check,
    output logic              rb_fail
);
    localparam int LAT_W = $clog2(RB_BOUND + 2);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RB_BOUND + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DUP,
        WAIT_RSP,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic [CNT_W-1:0]  orig_idx;
    logic [CNT_W-1:0]  dup_idx;
    logic [ADDR_W-1:0] orig_addr;
    logic [DATA_W-1:0] orig_data;
    logic [DATA_W-1:0] dup_data;
    logic              orig_got;
    logic              dup_got;
    logic [LAT_W-1:0]  lat_o;
    logic [LAT_W-1:0]  lat_d;

    logic             raw_req;
    logic             acc;
    logic             issue_orig;
    logic             issue_dup;
    logic             rsp;
    logic             orig_pend;
    logic             dup_pend;
    logic             orig_hit;
    logic             dup_hit;
    logic [LAT_W-1:0] lat_o_nx;
    logic [LAT_W-1:0] lat_d_nx;

    assign raw_req    = rd.ren_in & ~flush & ~reset;
    assign acc        = clk_en & raw_req;
    assign issue_orig = acc & exec_dup & (state == IDLE);
    assign issue_dup  = acc & exec_dup & (state == WAIT_DUP);

    // Address replay ignores clk_en so the presented address is always coherent
    assign rd.addr_out = (raw_req & exec_dup & (state == WAIT_DUP))
                         ? orig_addr : rd.addr_in;

    assign rsp       = clk_en & rd.valid_out & ~reset;
    assign orig_pend = (state != IDLE) & ~orig_got;
    assign dup_pend  = ((state == WAIT_RSP) | (state == DONE)) & ~dup_got;
    assign orig_hit  = rsp & orig_pend & (rsp_cnt == orig_idx);
    assign dup_hit   = rsp & ~orig_hit & dup_pend & (rsp_cnt == dup_idx);

    assign lat_o_nx = (orig_pend && lat_o != LAT_MAX) ? lat_o + 1'b1 : lat_o;
    assign lat_d_nx = (dup_pend && lat_d != LAT_MAX) ? lat_d + 1'b1 : lat_d;

    assign qed_check = ~qed_done | (orig_data == dup_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
            orig_idx  <= '0;
            dup_idx   <= '0;
            orig_addr <= '0;
            orig_data <= '0;
            dup_data  <= '0;
            orig_got  <= 1'b0;
            dup_got   <= 1'b0;
            lat_o     <= '0;
            lat_d     <= '0;
            qed_done  <= 1'b0;
            rb_fail   <= 1'b0;
        end else if (clk_en) begin
            if (acc) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (issue_orig) begin
                orig_addr <= rd.addr_in;
                orig_idx  <= req_cnt;
            end
            if (issue_dup) begin
                dup_idx <= req_cnt;
            end
            if (rsp) begin
                rsp_cnt <= rsp_cnt + 1'b1;
            end
            if (orig_hit) begin
                orig_data <= rd.data_out_in;
                orig_got  <= 1'b1;
            end
            if (dup_hit) begin
                dup_data <= rd.data_out_in;
                dup_got  <= 1'b1;
            end
            lat_o   <= lat_o_nx;
            lat_d   <= lat_d_nx;
            rb_fail <= rb_fail | (lat_o_nx == LAT_MAX) | (lat_d_nx == LAT_MAX);

            unique case (state)
                IDLE: begin
                    if (issue_orig) state <= WAIT_DUP;
                end
                WAIT_DUP: begin
                    if (issue_dup) state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (orig_got & dup_got) begin
                        state    <= DONE;
                        qed_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aqed_rd_checker.sv
// Bench for the A-QED read monitor: directed scenarios plus randomized traffic
// against a request/response bookkeeping model of the tagging rules.
module tb_aqed_rd_checker;
    logic clk = 1'b0;
    logic reset, clk_en, flush, exec_dup;
    logic qed_done, qed_check, rb_fail;

    aqed_rd_checker_if #(.ADDR_W(9), .DATA_W(16)) rd ();

    aqed_rd_checker #(
        .ADDR_W(9), .DATA_W(16), .CNT_W(32), .RB_BOUND(64)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
        .exec_dup(exec_dup), .rd(rd), .qed_done(qed_done),
        .qed_check(qed_check), .rb_fail(rb_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: request/response numbers and which numbers carry the tags
    int          m_req, m_rsp, o_idx, d_idx, age_o, age_d;
    bit          o_tag, d_tag, o_got, d_got, m_done, m_rbf;
    logic [8:0]  o_addr;
    logic [15:0] o_data, d_data;
    logic [8:0]  last_ao;
    logic [15:0] pq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_ao(bit r, bit fl, bit ex, bit ren,
                                            logic [8:0] a);
        return (!r && ren && !fl && ex && o_tag && !d_tag) ? o_addr : a;
    endfunction

    function automatic void model_clear();
        m_req = 0; m_rsp = 0; o_idx = 0; d_idx = 0; age_o = 0; age_d = 0;
        o_tag = 0; d_tag = 0; o_got = 0; d_got = 0; m_done = 0; m_rbf = 0;
        o_addr = '0; o_data = '0; d_data = '0;
    endfunction

    function automatic void model_update(bit r, bit ce, bit fl, bit ex,
                                         bit ren, logic [8:0] a, bit vo,
                                         logic [15:0] d);
        bit pend_o, pend_d, both;
        if (r) begin
            model_clear();
            return;
        end
        if (!ce) return;
        pend_o = o_tag && !o_got;
        pend_d = d_tag && !d_got;
        both   = o_got && d_got;
        if (vo) begin
            if (pend_o && m_rsp == o_idx) begin
                o_data = d; o_got = 1;
            end else if (pend_d && m_rsp == d_idx) begin
                d_data = d; d_got = 1;
            end
            m_rsp++;
        end
        if (pend_o) age_o = (age_o > 64) ? age_o : age_o + 1;
        if (pend_d) age_d = (age_d > 64) ? age_d : age_d + 1;
        if (age_o > 64 || age_d > 64) m_rbf = 1;
        if (both) m_done = 1;
        if (ren && !fl) begin
            if (ex && !o_tag) begin
                o_tag = 1; o_idx = m_req; o_addr = a;
            end else if (ex && !d_tag) begin
                d_tag = 1; d_idx = m_req;
            end
            m_req++;
        end
    endfunction

    task automatic step(input bit r, input bit ce, input bit fl, input bit ex,
                        input bit ren, input logic [8:0] a, input bit vo,
                        input logic [15:0] d);
        reset = r; clk_en = ce; flush = fl; exec_dup = ex;
        rd.ren_in = ren; rd.addr_in = a;
        rd.valid_out = vo; rd.data_out_in = d;
        #1;
        chk("addr_out", {23'd0, rd.addr_out}, {23'd0, model_ao(r, fl, ex, ren, a)});
        last_ao = rd.addr_out;
        model_update(r, ce, fl, ex, ren, a, vo, d);
        @(posedge clk);
        #1;
        chk("qed_done", {31'd0, qed_done}, {31'd0, m_done});
        chk("qed_check", {31'd0, qed_check},
            {31'd0, (!m_done || o_data == d_data)});
        chk("rb_fail", {31'd0, rb_fail}, {31'd0, m_rbf});
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, 9'h0, 0, 16'h0);
        step(1, 1, 0, 0, 0, 9'h0, 0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 9'h0, 0, 16'h0);
    endtask

    task automatic basic_seq(input logic [15:0] dup_word);
        do_reset();
        step(0, 1, 0, 1, 1, 9'h005, 0, 16'h0);
        step(0, 1, 0, 0, 1, 9'h007, 1, 16'hBEEF);
        step(0, 1, 0, 0, 1, 9'h009, 1, 16'h1111);
        step(0, 1, 0, 1, 1, 9'h033, 1, 16'h2222);
        chk("dup_addr_replay", {23'd0, last_ao}, 32'h005);
        step(0, 1, 0, 0, 0, 9'h000, 1, dup_word);
        idle(2);
    endtask

    function automatic logic [15:0] mem_of(logic [8:0] a);
        return 16'(a) * 16'h9E37 ^ 16'h1234;
    endfunction

    initial begin
        logic [8:0]  a, ao;
        logic [15:0] dv;
        bit r, ce, fl, ex, ren, vo;
        int vprob;

        model_clear();
        do_reset();
        chk("reset_done", {31'd0, qed_done}, 32'd0);
        chk("reset_check", {31'd0, qed_check}, 32'd1);
        chk("reset_rb", {31'd0, rb_fail}, 32'd0);

        basic_seq(16'hBEEF);
        chk("match_done", {31'd0, qed_done}, 32'd1);
        chk("match_check", {31'd0, qed_check}, 32'd1);

        basic_seq(16'hBEEE);
        chk("mismatch_done", {31'd0, qed_done}, 32'd1);
        chk("mismatch_check", {31'd0, qed_check}, 32'd0);

        // Flushed request must not be tagged nor counted
        do_reset();
        step(0, 1, 1, 1, 1, 9'h011, 0, 16'h0);
        step(0, 1, 0, 1, 1, 9'h022, 0, 16'h0);
        step(0, 1, 0, 0, 0, 9'h000, 1, 16'hAAAA);
        step(0, 1, 0, 1, 1, 9'h044, 0, 16'h0);
        chk("flush_replay", {23'd0, last_ao}, 32'h022);
        step(0, 1, 1, 0, 0, 9'h000, 1, 16'hAAAA);
        idle(2);
        chk("flush_done", {31'd0, qed_done}, 32'd1);
        chk("flush_check", {31'd0, qed_check}, 32'd1);

        // Bounded response: 64 waits are allowed, the 65th trips
        do_reset();
        step(0, 1, 0, 1, 1, 9'h005, 0, 16'h0);
        idle(64);
        chk("rb_at_bound", {31'd0, rb_fail}, 32'd0);
        idle(1);
        chk("rb_past_bound", {31'd0, rb_fail}, 32'd1);
        idle(5);
        chk("rb_sticky", {31'd0, rb_fail}, 32'd1);
        do_reset();
        chk("rb_cleared", {31'd0, rb_fail}, 32'd0);

        // clk_en low freezes everything while valid_out toggles
        do_reset();
        step(0, 1, 0, 1, 1, 9'h0A0, 0, 16'h0);
        step(0, 1, 0, 1, 1, 9'h0B0, 0, 16'h0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 0, 9'h0, i[0], 16'h5555);
        step(0, 1, 0, 0, 0, 9'h0, 1, 16'h7777);
        step(0, 1, 0, 0, 0, 9'h0, 1, 16'h7777);
        idle(2);
        chk("ce_done", {31'd0, qed_done}, 32'd1);
        chk("ce_check", {31'd0, qed_check}, 32'd1);

        // Randomized traffic with an in-order memory behind the port
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            pq.delete();
            vprob = (ep == 3) ? 2 : 50;
            for (int cyc = 0; cyc < 300; cyc++) begin
                r   = ($urandom_range(0, 299) == 0);
                ce  = ($urandom_range(0, 9) != 0);
                fl  = ($urandom_range(0, 9) == 0);
                ex  = ($urandom_range(0, 4) == 0);
                ren = $urandom_range(0, 1) != 0;
                a   = 9'($urandom_range(0, 511));
                vo  = 0;
                dv  = 16'($urandom);
                if (pq.size() > 0 && $urandom_range(0, 99) < vprob) begin
                    vo = 1;
                    dv = pq[0];
                    if ($urandom_range(0, 7) == 0) dv = dv ^ 16'h0100;
                end
                if (!ce) vo = $urandom_range(0, 1) != 0;
                ao = model_ao(r, fl, ex, ren, a);
                if (r) pq.delete();
                else if (ce) begin
                    if (vo) void'(pq.pop_front());
                    if (ren && !fl) pq.push_back(mem_of(ao));
                end
                step(r, ce, fl, ex, ren, a, vo, dv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
